vldst_unit: RTL

VLDST_UNIT -- requirements
Module: vldst_unit

---
 rtl/vldst_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vldst_unit.sv
// Strided vector load/store engine: moves the 16 lanes of one 256-bit vector register
// to or from word memory, one element per memory handshake.
module vldst_unit #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Op,
    input  logic [2:0]        VAddr,
    input  logic [ADDR_W-1:0] MemBase,
    input  logic [ADDR_W-1:0] Stride,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    output logic              MemWr,
    output logic [15:0]       MemDataOut,
    input  logic [15:0]       MemDataIn,
    input  logic              MemAck,
    output logic [2:0]        RegAddr,
    output logic              RegRd,
    output logic              RegWr,
    output logic [255:0]      RegDataOut,
    input  logic [255:0]      RegDataIn
);

    localparam int unsigned LANE_W = 16;
    localparam int unsigned LANES  = 16;
    localparam int unsigned VEC_W  = LANE_W * LANES;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned REG_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RREG = 3'd1,
        CAPT = 3'd2,
        MEM  = 3'd3,
        WREG = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [REG_W-1:0]    vaddr_q, vaddr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VEC_W-1:0]    vbuf_q, vbuf_d;
    logic [LANE_W-1:0]   mem_dout_q, mem_dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic                reg_wr_q, reg_wr_d;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered strobes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q       <= 1'b0;
            vaddr_q    <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            vbuf_q     <= '0;
            mem_dout_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
        end else begin
            op_q       <= op_d;
            vaddr_q    <= vaddr_d;
            stride_q   <= stride_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            vbuf_q     <= vbuf_d;
            mem_dout_q <= mem_dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            reg_rd_q   <= reg_rd_d;
            reg_wr_q   <= reg_wr_d;
        end
    end

    // Next state; strobes are decoded from the next state so they line up with it
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        vaddr_d  = vaddr_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        vbuf_d   = vbuf_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    vaddr_d  = VAddr;
                    stride_d = Stride;
                    addr_d   = MemBase;
                    idx_d    = '0;
                    state_d  = Op ? RREG : MEM;
                end
            end
            RREG: state_d = CAPT;
            CAPT: begin
                vbuf_d  = RegDataIn;
                state_d = MEM;
            end
            MEM: begin
                // Running address sum gives MemBase + i*Stride modulo 2^ADDR_W
                if (MemAck) begin
                    if (!op_q) begin
                        vbuf_d[{idx_q, 4'b0000} +: LANE_W] = MemDataIn;
                    end
                    idx_d  = idx_q + IDX_W'(1);
                    addr_d = addr_q + stride_q;
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        state_d = op_q ? DONE : WREG;
                    end
                end
            end
            WREG: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == RREG) || (state_d == CAPT) ||
                     (state_d == MEM)  || (state_d == WREG);
        done_d     = (state_d == DONE);
        mem_rd_d   = (state_d == MEM) && !op_d;
        mem_wr_d   = (state_d == MEM) && op_d;
        reg_rd_d   = (state_d == RREG);
        reg_wr_d   = (state_d == WREG);
        mem_dout_d = vbuf_d[{idx_d, 4'b0000} +: LANE_W];
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign MemAddr    = addr_q;
    assign MemRd      = mem_rd_q;
    assign MemWr      = mem_wr_q;
    assign MemDataOut = mem_dout_q;
    assign RegAddr    = vaddr_q;
    assign RegRd      = reg_rd_q;
    assign RegWr      = reg_wr_q;
    assign RegDataOut = vbuf_q;

endmodule
